// File: rtl/sram_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sram_pkg : shared types and defaults for the 16-bit async SRAM controller
// Revision : 1.0
// ----------------------------------------------------------------------------
package sram_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOW  = 2'd1,
    ST_HIGH = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam int SRAM_DATA_WIDTH         = 16;
  localparam int DEFAULT_BASE_ADDR       = 1024;
  localparam int DEFAULT_WAIT_CYCLES     = 1;
  localparam int DEFAULT_SRAM_ADDR_WIDTH = 18;

endpackage
`default_nettype wire

// File: rtl/sram_phase_timer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sram_phase_timer : per-phase down-counter with first/last cycle flags
// Revision : 1.0
// ----------------------------------------------------------------------------
module sram_phase_timer #(
  parameter int WAIT_CYCLES = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic first,
  output logic last
);

  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(WAIT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             first_q, first_d;

  always_comb begin
    cnt_d   = cnt_q;
    first_d = 1'b0;
    if (load) begin
      cnt_d   = LOAD_VAL;
      first_d = 1'b1;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      first_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      first_q <= first_d;
    end
  end

  assign first = first_q;
  assign last  = (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/sram_controller.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sram_controller : 32-bit word access as two half-word phases on async SRAM
// Revision : 1.0
// ----------------------------------------------------------------------------
module sram_controller
  import sram_pkg::*;
#(
  parameter int BASE_ADDR       = DEFAULT_BASE_ADDR,
  parameter int WAIT_CYCLES     = DEFAULT_WAIT_CYCLES,
  parameter int SRAM_ADDR_WIDTH = DEFAULT_SRAM_ADDR_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       rd_en,
  input  logic                       wr_en,
  input  logic [31:0]                address,
  input  logic [31:0]                write_data,
  output logic [31:0]                read_data,
  output logic                       ready,
  output logic [SRAM_ADDR_WIDTH-1:0] sram_addr,
  output logic [SRAM_DATA_WIDTH-1:0] sram_dq_out,
  output logic                       sram_dq_oe,
  input  logic [SRAM_DATA_WIDTH-1:0] sram_dq_in,
  output logic                       sram_we_n
);

  localparam int IDX_W = SRAM_ADDR_WIDTH - 1;

  state_t                       state_q, state_d;
  logic                         op_wr_q, op_wr_d;
  logic [SRAM_DATA_WIDTH-1:0]   wdata_hi_q, wdata_hi_d;
  logic [31:0]                  read_data_q, read_data_d;
  logic [SRAM_ADDR_WIDTH-1:0]   sram_addr_q, sram_addr_d;
  logic [SRAM_DATA_WIDTH-1:0]   dq_out_q, dq_out_d;

  logic [IDX_W-1:0] w_idx;
  logic             w_req;
  logic             w_load;
  logic             w_first;
  logic             w_last;
  logic             w_write_phase;

  // Out-of-range addresses wrap: the upper index bits are simply dropped.
  assign w_idx  = IDX_W'((address - 32'(BASE_ADDR)) >> 2);
  assign w_req  = rd_en | wr_en;
  assign w_load = ((state_q == ST_IDLE) && w_req) || ((state_q == ST_LOW) && w_last);

  sram_phase_timer #(
    .WAIT_CYCLES(WAIT_CYCLES)
  ) u_timer (
    .clk  (clk),
    .rst  (rst),
    .load (w_load),
    .first(w_first),
    .last (w_last)
  );

  always_comb begin
    state_d     = state_q;
    op_wr_d     = op_wr_q;
    wdata_hi_d  = wdata_hi_q;
    read_data_d = read_data_q;
    sram_addr_d = sram_addr_q;
    dq_out_d    = dq_out_q;
    case (state_q)
      ST_IDLE: begin
        if (w_req) begin
          state_d     = ST_LOW;
          op_wr_d     = wr_en;
          wdata_hi_d  = write_data[31:16];
          sram_addr_d = {w_idx, 1'b0};
          if (wr_en) dq_out_d = write_data[15:0];
        end
      end
      ST_LOW: begin
        if (w_last) begin
          state_d        = ST_HIGH;
          sram_addr_d[0] = 1'b1;
          if (op_wr_q) dq_out_d = wdata_hi_q;
          else         read_data_d[15:0] = sram_dq_in;
        end
      end
      ST_HIGH: begin
        if (w_last) begin
          state_d = ST_DONE;
          if (!op_wr_q) read_data_d[31:16] = sram_dq_in;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      op_wr_q     <= 1'b0;
      wdata_hi_q  <= '0;
      read_data_q <= '0;
      sram_addr_q <= '0;
      dq_out_q    <= '0;
    end else begin
      state_q     <= state_d;
      op_wr_q     <= op_wr_d;
      wdata_hi_q  <= wdata_hi_d;
      read_data_q <= read_data_d;
      sram_addr_q <= sram_addr_d;
      dq_out_q    <= dq_out_d;
    end
  end

  // Strobe released in the last cycle of a multi-cycle phase for data hold.
  assign w_write_phase = op_wr_q && ((state_q == ST_LOW) || (state_q == ST_HIGH));
  assign sram_we_n     = ~(w_write_phase & ~(w_last & ~w_first));
  assign sram_dq_oe    = w_write_phase;

  assign ready       = (state_q == ST_DONE) || ((state_q == ST_IDLE) && !rd_en && !wr_en);
  assign read_data   = read_data_q;
  assign sram_addr   = sram_addr_q;
  assign sram_dq_out = dq_out_q;

endmodule
`default_nettype wire

// File: tb/tb_sram_controller.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_sram_controller : directed bench, W=1 and W=3 instances with SRAM models
// Revision : 1.0
// ----------------------------------------------------------------------------
module tb_sram_controller;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // W=1 instance
  logic        rd1 = 0, wr1 = 0;
  logic [31:0] addr1 = 0, wd1 = 0, rdata1;
  logic        rdy1, oe1, wen1;
  logic [17:0] sa1;
  logic [15:0] dqo1, dqi1;
  logic [15:0] mem1 [0:15];

  // W=3 instance
  logic        rd3 = 0, wr3 = 0;
  logic [31:0] addr3 = 0, wd3 = 0, rdata3;
  logic        rdy3, oe3, wen3;
  logic [17:0] sa3;
  logic [15:0] dqo3, dqi3;
  logic [15:0] mem3 [0:15];

  sram_controller #(.BASE_ADDR(1024), .WAIT_CYCLES(1), .SRAM_ADDR_WIDTH(18)) dut1 (
    .clk(clk), .rst(rst), .rd_en(rd1), .wr_en(wr1), .address(addr1),
    .write_data(wd1), .read_data(rdata1), .ready(rdy1), .sram_addr(sa1),
    .sram_dq_out(dqo1), .sram_dq_oe(oe1), .sram_dq_in(dqi1), .sram_we_n(wen1)
  );

  sram_controller #(.BASE_ADDR(1024), .WAIT_CYCLES(3), .SRAM_ADDR_WIDTH(18)) dut3 (
    .clk(clk), .rst(rst), .rd_en(rd3), .wr_en(wr3), .address(addr3),
    .write_data(wd3), .read_data(rdata3), .ready(rdy3), .sram_addr(sa3),
    .sram_dq_out(dqo3), .sram_dq_oe(oe3), .sram_dq_in(dqi3), .sram_we_n(wen3)
  );

  // Behavioural async SRAM: writes land while the strobe is low and the bus is driven.
  assign dqi1 = mem1[sa1[3:0]];
  assign dqi3 = mem3[sa3[3:0]];
  always @(posedge clk) begin
    if (!wen1 && oe1) mem1[sa1[3:0]] <= dqo1;
    if (!wen3 && oe3) mem3[sa3[3:0]] <= dqo3;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      mem1[i] = 16'h0;
      mem3[i] = 16'h0;
    end

    // Reset and idle
    tick(); tick();
    rst = 1'b0;
    tick();
    check("idle_ready", {31'd0, rdy1}, 32'd1);
    check("idle_we_n", {31'd0, wen1}, 32'd1);
    check("idle_oe", {31'd0, oe1}, 32'd0);
    check("idle_rdata", rdata1, 32'h0);
    check("idle_addr", {14'd0, sa1}, 32'd0);

    // W=1 write 0xDEADBEEF at 1024
    wr1 = 1; addr1 = 32'd1024; wd1 = 32'hDEADBEEF;
    #1;
    check("wr_c0_ready", {31'd0, rdy1}, 32'd0);
    tick();
    check("wr_low_ready", {31'd0, rdy1}, 32'd0);
    check("wr_low_addr", {14'd0, sa1}, 32'd0);
    check("wr_low_dq", {16'd0, dqo1}, 32'h0000BEEF);
    check("wr_low_oe", {31'd0, oe1}, 32'd1);
    check("wr_low_we_n", {31'd0, wen1}, 32'd0);
    tick();
    check("wr_high_ready", {31'd0, rdy1}, 32'd0);
    check("wr_high_addr", {14'd0, sa1}, 32'd1);
    check("wr_high_dq", {16'd0, dqo1}, 32'h0000DEAD);
    check("wr_high_we_n", {31'd0, wen1}, 32'd0);
    tick();
    check("wr_done_ready", {31'd0, rdy1}, 32'd1);
    wr1 = 0;
    tick();
    check("wr_idle_oe", {31'd0, oe1}, 32'd0);
    check("wr_idle_we_n", {31'd0, wen1}, 32'd1);
    check("wr_idle_rdata", rdata1, 32'h0);

    // W=1 read back
    rd1 = 1; addr1 = 32'd1024;
    tick();
    check("rd_low_oe", {31'd0, oe1}, 32'd0);
    check("rd_low_we_n", {31'd0, wen1}, 32'd1);
    tick();
    check("rd_high_addr", {14'd0, sa1}, 32'd1);
    check("rd_high_ready", {31'd0, rdy1}, 32'd0);
    tick();
    check("rd_done_ready", {31'd0, rdy1}, 32'd1);
    check("rd_done_data", rdata1, 32'hDEADBEEF);
    rd1 = 0;
    tick();

    // Simultaneous read+write at 1032: write wins
    rd1 = 1; wr1 = 1; addr1 = 32'd1032; wd1 = 32'hCAFEF00D;
    tick();
    check("both_low_addr", {14'd0, sa1}, 32'd4);
    check("both_low_we_n", {31'd0, wen1}, 32'd0);
    check("both_low_dq", {16'd0, dqo1}, 32'h0000F00D);
    tick();
    check("both_high_addr", {14'd0, sa1}, 32'd5);
    check("both_high_dq", {16'd0, dqo1}, 32'h0000CAFE);
    tick();
    check("both_done_rdata", rdata1, 32'hDEADBEEF);
    check("both_mem4", {16'd0, mem1[4]}, 32'h0000F00D);
    check("both_mem5", {16'd0, mem1[5]}, 32'h0000CAFE);
    rd1 = 0; wr1 = 0;
    tick();

    // Back-to-back write then read at 1028
    wr1 = 1; addr1 = 32'd1028; wd1 = 32'h12345678;
    tick(); tick(); tick();
    check("b2b_wr_done", {31'd0, rdy1}, 32'd1);
    wr1 = 0; rd1 = 1;
    tick();
    check("b2b_c4_ready", {31'd0, rdy1}, 32'd0);
    check("b2b_c4_oe", {31'd0, oe1}, 32'd0);
    tick();
    check("b2b_c5_addr", {14'd0, sa1}, 32'd2);
    check("b2b_c5_we_n", {31'd0, wen1}, 32'd1);
    tick();
    check("b2b_c6_addr", {14'd0, sa1}, 32'd3);
    tick();
    check("b2b_done_ready", {31'd0, rdy1}, 32'd1);
    check("b2b_done_data", rdata1, 32'h12345678);
    rd1 = 0;
    tick();

    // W=3 write then read at 1024
    wr3 = 1; addr3 = 32'd1024; wd3 = 32'hA5A50F0F;
    for (int c = 1; c <= 7; c++) begin
      tick();
      if (c <= 3) check($sformatf("w3_wr_addr_c%0d", c), {14'd0, sa3}, 32'd0);
      else if (c <= 6) check($sformatf("w3_wr_addr_c%0d", c), {14'd0, sa3}, 32'd1);
      if (c <= 6) check($sformatf("w3_wr_we_n_c%0d", c), {31'd0, wen3},
                        (c == 3 || c == 6) ? 32'd1 : 32'd0);
      check($sformatf("w3_wr_ready_c%0d", c), {31'd0, rdy3}, (c == 7) ? 32'd1 : 32'd0);
    end
    wr3 = 0;
    tick();
    check("w3_mem0", {16'd0, mem3[0]}, 32'h00000F0F);
    check("w3_mem1", {16'd0, mem3[1]}, 32'h0000A5A5);

    rd3 = 1; addr3 = 32'd1024;
    for (int c = 1; c <= 7; c++) begin
      tick();
      check($sformatf("w3_rd_we_n_c%0d", c), {31'd0, wen3}, 32'd1);
      check($sformatf("w3_rd_ready_c%0d", c), {31'd0, rdy3}, (c == 7) ? 32'd1 : 32'd0);
    end
    check("w3_rd_data", rdata3, 32'hA5A50F0F);
    rd3 = 0;
    tick();

    // Reset during HIGH phase of a W=1 write
    wr1 = 1; addr1 = 32'd1036; wd1 = 32'h55AA33CC;
    tick(); tick();
    check("rst_pre_we_n", {31'd0, wen1}, 32'd0);
    rst = 1;
    tick();
    check("rst_we_n", {31'd0, wen1}, 32'd1);
    check("rst_oe", {31'd0, oe1}, 32'd0);
    check("rst_rdata", rdata1, 32'h0);
    check("rst_addr", {14'd0, sa1}, 32'd0);
    check("rst_dq", {16'd0, dqo1}, 32'd0);
    check("rst_ready_held_req", {31'd0, rdy1}, 32'd0);
    rst = 0; wr1 = 0;
    #1;
    check("rst_ready_idle", {31'd0, rdy1}, 32'd1);
    tick();
    check("rst_after_ready", {31'd0, rdy1}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
